// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the program counter, issues word
//            requests to instruction memory (request/grant, in-order
//            responses), buffers returned words in a 2-entry fetch queue and
//            drives the IF/ID pipeline register. Accepts branch/jump
//            redirects resolved downstream.
// Ports    : clk, rst               clock, async active-high reset
//            stall                  hold IF/ID
//            redirect, redirect_pc  taken branch/jump and 12-bit target
//            imem_req/addr/gnt      request channel (word address)
//            imem_rvalid/rdata      in-order response channel
//            inst, next_pc,         IF/ID register (instruction, fetch PC+4,
//            id_valid               real-instruction flag)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [12:0] RESET_PC = 13'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [11:0] redirect_pc,
  output logic        imem_req,
  output logic [10:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [12:0] next_pc,
  output logic        id_valid
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [12:0] pc_q;
  logic [1:0]  out_q;          // live outstanding requests
  logic [1:0]  disc_q;         // outstanding requests whose words get dropped

  // In-flight tag FIFO: PC+4 of every live request, in issue order.
  // Its occupancy always equals out_q, so no separate count is kept.
  logic [12:0] tag_mem [2];
  logic        tag_wp;
  logic        tag_rp;

  // Fetch queue: {word, PC+4}
  logic [31:0] q_word [2];
  logic [12:0] q_npc  [2];
  logic        q_wp;
  logic        q_rp;
  logic [1:0]  q_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic        pop;
  logic [2:0]  credit_used;
  logic        gnt_fire;
  logic        rsp_disc;
  logic        rsp_live;
  logic        rsp_any;
  logic [12:0] pc_plus4;
  logic [12:0] redirect_target;
  logic        unused_redirect_lsbs;

  assign pop = !stall && (q_count != 2'd0) && !redirect;

  // Issue credit covers every slot a word could eventually occupy: queued
  // entries, live requests and requests still owed a discarded response.
  // An entry leaving the queue this cycle frees its slot immediately, which
  // is what allows one instruction per cycle with single-cycle memory.
  assign credit_used = {1'b0, out_q} + {1'b0, disc_q} + {1'b0, q_count}
                     - {2'b00, pop};

  // Gated by rst so no request leaks out while the reset is held.
  assign imem_req  = !rst && !redirect && (credit_used < 3'd2);
  assign imem_addr = pc_q[12:2];
  assign gnt_fire  = imem_req && imem_gnt;

  // Discards are always owed by older requests than live ones, so they are
  // consumed first. A response with nothing outstanding matches neither term
  // and is ignored.
  assign rsp_disc = imem_rvalid && (disc_q != 2'd0);
  assign rsp_live = imem_rvalid && (disc_q == 2'd0) && (out_q != 2'd0);
  assign rsp_any  = rsp_disc || rsp_live;

  assign pc_plus4        = pc_q + 13'd4;
  assign redirect_target = {1'b0, redirect_pc[11:2], 2'b00};

  // Target is word aligned; the byte-offset bits carry no information.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // --------------------------------------------------------------------------
  // Storage arrays (contents qualified by pointers/counts, so no reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (gnt_fire) begin
      tag_mem[tag_wp] <= pc_plus4;
    end
    if (rsp_live && !redirect) begin
      q_word[q_wp] <= imem_rdata;
      q_npc[q_wp]  <= tag_mem[tag_rp];
    end
  end

  // --------------------------------------------------------------------------
  // Control state and IF/ID register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      out_q    <= 2'd0;
      disc_q   <= 2'd0;
      tag_wp   <= 1'b0;
      tag_rp   <= 1'b0;
      q_wp     <= 1'b0;
      q_rp     <= 1'b0;
      q_count  <= 2'd0;
      inst     <= NOP_INST;
      next_pc  <= 13'd0;
      id_valid <= 1'b0;
    end else if (redirect) begin
      // No grant can coincide with a redirect (imem_req is low), so all
      // live requests become discards; a response arriving now is consumed
      // here and dropped.
      pc_q     <= redirect_target;
      disc_q   <= disc_q + out_q - {1'b0, rsp_any};
      out_q    <= 2'd0;
      tag_wp   <= 1'b0;
      tag_rp   <= 1'b0;
      q_wp     <= 1'b0;
      q_rp     <= 1'b0;
      q_count  <= 2'd0;
      inst     <= NOP_INST;
      id_valid <= 1'b0;
    end else begin
      if (gnt_fire) begin
        pc_q   <= pc_plus4;
        tag_wp <= ~tag_wp;
      end

      if (rsp_live) begin
        tag_rp <= ~tag_rp;
        q_wp   <= ~q_wp;
      end

      out_q <= out_q + {1'b0, gnt_fire} - {1'b0, rsp_live};

      if (rsp_disc) begin
        disc_q <= disc_q - 2'd1;
      end

      if (pop) begin
        q_rp <= ~q_rp;
      end
      q_count <= q_count + {1'b0, rsp_live} - {1'b0, pop};

      // IF/ID: hold on stall, otherwise take the queue head or a bubble.
      // A bubble keeps next_pc so the last fetch address stays visible.
      if (!stall) begin
        if (pop) begin
          inst     <= q_word[q_rp];
          next_pc  <= q_npc[q_rp];
          id_valid <= 1'b1;
        end else begin
          inst     <= NOP_INST;
          id_valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A behavioural instruction
//            memory returns addr*4+0x100 after a configurable latency; an
//            expected-instruction queue is filled at each grant from the
//            bench's own PC model and drained as IF/ID delivers words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [12:0] RESET_PC = 13'h0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = 12'h000;
  logic        imem_req;
  logic [10:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic [12:0] next_pc;
  logic        id_valid;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .next_pc     (next_pc),
    .id_valid    (id_valid)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int lat          = 1;
  int delivered    = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_rsp_t;

  typedef struct {
    logic [31:0] inst;
    logic [12:0] npc;
  } exp_t;

  mem_rsp_t    mem_q[$];
  exp_t        sb[$];
  logic [12:0] exp_pc = RESET_PC;

  // One clock cycle: sample the handshake before the edge, then advance the
  // memory model and scoreboard after it.
  task automatic tick();
    logic        granted;
    logic [10:0] gaddr;
    logic        was_stall;
    logic        was_redir;
    logic [11:0] rpc;
    logic [31:0] h_inst;
    logic [12:0] h_npc;
    logic        h_valid;
    mem_rsp_t    m;
    exp_t        e;
    #1;
    granted   = imem_req && imem_gnt;
    gaddr     = imem_addr;
    was_stall = stall;
    was_redir = redirect;
    rpc       = redirect_pc;
    h_inst    = inst;
    h_npc     = next_pc;
    h_valid   = id_valid;
    @(posedge clk);
    #1;
    if (granted) begin
      tests_run++;
      if (gaddr !== exp_pc[12:2]) begin
        tests_failed++;
        $display("FAIL grant_addr: got %h expected %h (cycle %0d)", gaddr, exp_pc[12:2], cyc);
      end
      m.due  = cyc + lat;
      m.data = 32'(gaddr) * 32'd4 + 32'h100;
      mem_q.push_back(m);
      e.inst = 32'(exp_pc) + 32'h100;
      e.npc  = exp_pc + 13'd4;
      sb.push_back(e);
      exp_pc = exp_pc + 13'd4;
    end
    cyc++;
    if (was_redir) begin
      sb.delete();
      exp_pc = {1'b0, rpc[11:2], 2'b00};
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
      void'(mem_q.pop_front());
    end
    if (was_redir) begin
      tests_run++;
      if (id_valid !== 1'b0 || inst !== NOP_INST) begin
        tests_failed++;
        $display("FAIL redirect_bubble: got valid=%b inst=%h expected valid=0 inst=%h", id_valid, inst, NOP_INST);
      end
    end else if (was_stall) begin
      tests_run++;
      if (inst !== h_inst || next_pc !== h_npc || id_valid !== h_valid) begin
        tests_failed++;
        $display("FAIL stall_hold: got %h/%h/%b expected %h/%h/%b", inst, next_pc, id_valid, h_inst, h_npc, h_valid);
      end
    end else if (id_valid === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_valid: got inst=%h next_pc=%h expected bubble", inst, next_pc);
      end else begin
        e = sb.pop_front();
        if (inst !== e.inst || next_pc !== e.npc) begin
          tests_failed++;
          $display("FAIL ifid_data: got %h/%h expected %h/%h", inst, next_pc, e.inst, e.npc);
        end
      end
      delivered++;
    end else begin
      tests_run++;
      if (inst !== NOP_INST) begin
        tests_failed++;
        $display("FAIL bubble_nop: got %h expected %h", inst, NOP_INST);
      end
    end
  endtask

  task automatic assert_reset();
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    mem_q.delete();
    sb.delete();
    exp_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    assert_reset();
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_req: got %b expected 0", imem_req);
    end
    tests_run++;
    if (inst !== NOP_INST || id_valid !== 1'b0 || next_pc !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_ifid: got %h/%h/%b expected %h/0000/0", inst, next_pc, id_valid, NOP_INST);
    end
    release_reset();
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC[12:2]) begin
      tests_failed++;
      $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC[12:2]);
    end
  endtask

  task automatic test_stream();
    logic exp_v;
    lat = 1;
    assert_reset();
    release_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = (i == 2);
      tests_run++;
      if (id_valid !== exp_v) begin
        tests_failed++;
        $display("FAIL first_latency: cycle %0d got valid=%b expected %b", i + 1, id_valid, exp_v);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (id_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL sustained: got valid=%b expected 1", id_valid);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (imem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_req: stall cycle %0d got req=%b expected 0", i, imem_req);
      end
      tick();
    end
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (id_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_resume: got valid=%b expected 1", id_valid);
      end
    end
  endtask

  task automatic test_redirect();
    int  n;
    logic found;
    lat = 3;
    assert_reset();
    release_reset();
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 12'h040;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL redirect_req: got %b expected 0", imem_req);
    end
    tick();
    redirect = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL discard_credit: got req=%b expected 0", imem_req);
    end
    tick();
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 11'h010) begin
      tests_failed++;
      $display("FAIL target_req: got req=%b addr=%h expected req=1 addr=010", imem_req, imem_addr);
    end
    found = 1'b0;
    n = 0;
    while (!found && n < 12) begin
      tick();
      n++;
      if (id_valid === 1'b1) found = 1'b1;
    end
    tests_run++;
    if (!found || next_pc !== 13'h0044 || inst !== 32'h0000_0140) begin
      tests_failed++;
      $display("FAIL redirect_target: got found=%b %h/%h expected 1 00000140/0044", found, inst, next_pc);
    end
  endtask

  task automatic test_redirect_stall();
    int d0;
    lat = 1;
    assert_reset();
    release_reset();
    repeat (6) tick();
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 12'h203;
    tick();
    stall    = 1'b0;
    redirect = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 11'h080) begin
      tests_failed++;
      $display("FAIL redirect_stall_pc: got req=%b addr=%h expected req=1 addr=080", imem_req, imem_addr);
    end
    d0 = delivered;
    repeat (6) tick();
    tests_run++;
    if (delivered - d0 < 3) begin
      tests_failed++;
      $display("FAIL redirect_stall_flow: got %0d deliveries expected >= 3", delivered - d0);
    end
  endtask

  task automatic test_wrap();
    logic seen;
    int   n;
    lat = 1;
    assert_reset();
    release_reset();
    redirect    = 1'b1;
    redirect_pc = 12'hFFC;
    tick();
    redirect = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 1100) begin
      tick();
      n++;
      if (id_valid === 1'b1 && inst === 32'h0000_20FC) begin
        seen = 1'b1;
        tests_run++;
        if (next_pc !== 13'h0000) begin
          tests_failed++;
          $display("FAIL wrap_next_pc: got %h expected 0000", next_pc);
        end
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL wrap_reached: got seen=0 expected 1");
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    lat = 3;
    assert_reset();
    release_reset();
    repeat (5) tick();
    stall = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (id_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_valid: got %b expected 1", id_valid);
    end
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    tests_run++;
    if (inst !== NOP_INST || id_valid !== 1'b0 || imem_req !== 1'b0 || next_pc !== 13'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h/%h/%b req=%b expected %h/0000/0 req=0", inst, next_pc, id_valid, imem_req, NOP_INST);
    end
    assert_reset();
    release_reset();
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC[12:2]) begin
      tests_failed++;
      $display("FAIL restart_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC[12:2]);
    end
    repeat (10) tick();
  endtask

  task automatic test_back_to_back();
    int d0;
    lat = 2;
    assert_reset();
    release_reset();
    d0 = delivered;
    for (int i = 0; i < 80; i++) begin
      imem_gnt = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      tick();
    end
    imem_gnt = 1'b1;
    stall    = 1'b0;
    repeat (6) tick();
    tests_run++;
    if (delivered - d0 < 10) begin
      tests_failed++;
      $display("FAIL random_flow: got %0d deliveries expected >= 10", delivered - d0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: owns the program counter, issues word requests to instruction memory over a request/grant plus in-order response handshake, and buffers returned words in a 2-entry fetch queue. It drives the IF/ID pipeline register (`inst`, `next_pc`) consumed by immediate generation and register-file addressing in the datapath. It also accepts branch/jump redirects resolved downstream (12-bit target from the MEM-stage ALU result).

## Interface
- `RESET_PC`, default 13'h0000: byte address of the first fetch after reset; bits [1:0] must be 0.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  hazard hold: IF/ID register keeps its value.
- `redirect`  in  1  taken branch/jump this cycle.
- `redirect_pc`  in  12  target byte address, zero-extended to 13 bits, bits [1:0] ignored (treated as 0).
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  11  word address = `pc_q[12:2]`.
- `imem_gnt`  in  1  request accepted this cycle (handshake = `imem_req && imem_gnt`).
- `imem_rvalid`  in  1  response word valid; responses return in request order, no earlier than the cycle after grant.
- `imem_rdata`  in  32  response word, sampled only when `imem_rvalid`.
- `inst`  out  32  IF/ID instruction.
- `next_pc`  out  13  IF/ID fetch address + 4.
- `id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- State: `pc_q` (13b), live outstanding count `out_q` (0..2), discard count `disc_q` (0..2), 2-entry in-flight tag FIFO (fetch PC+4 per live request), 2-entry fetch queue {word, PC+4}, and the IF/ID register.
- Reset values: `pc_q`=RESET_PC, all counts/FIFOs empty, `inst`=32'h0000_0013 (NOP), `next_pc`=0, `id_valid`=0, `imem_req`=0 while `rst` high.
- pop = `!stall && q_count>0 && !redirect`.
- `imem_req` = `!redirect && (out_q + disc_q + q_count - pop) < 2`. Combinational from state and `stall`/`redirect`.
- Grant: `pc_q` <= `pc_q`+4 (mod 2^13, wraps 13'h1FFC -> 0); push `pc_q`+4 to the tag FIFO; `out_q`++.
- Response: if `disc_q`>0, drop the word and decrement `disc_q`. Otherwise push {`imem_rdata`, tag head} into the fetch queue, pop the tag FIFO, and decrement `out_q`.
- Responses with `out_q`=`disc_q`=0 are a protocol violation: ignored, no state change.
- IF/ID when no redirect: on `stall`, hold. Else if pop, load the queue head and set `id_valid`=1. Else load NOP, `next_pc` unchanged, `id_valid`=0.
- Redirect (overrides `stall`):
  - `pc_q` <= {1'b0, `redirect_pc`[11:2], 2'b00}.
  - Fetch queue and tag FIFO cleared.
  - IF/ID <= NOP with `id_valid`=0.
  - `disc_q` <= `disc_q` + `out_q` − (1 if `imem_rvalid` this cycle, else 0).
  - `out_q` <= 0.
  - A response arriving in the redirect cycle is dropped.
- Queue full (2 entries) cannot overflow: issue credit counts queue entries plus all outstanding requests.

## Timing
- Minimum latency with 1-cycle memory: grant in cycle N, `imem_rvalid` in N+1, IF/ID updated at the end of N+2, visible in cycle N+3.
- Sustained 1 instruction/cycle with 1-cycle memory and no stall; issue is allowed in the same cycle as a pop.
- First `imem_req` is asserted in the first cycle after `rst` deasserts, with `imem_addr` = RESET_PC[12:2].
- Redirect in cycle R:
  - `imem_req`=0 in R.
  - New-target request is issued in R+1 if credit allows (discard slots still count toward credit).
  - First target instruction reaches IF/ID no earlier than the end of R+3.
- `rst` mid-operation: immediate return to reset values. In-flight memory responses after reset release are not tracked; memory must also be reset.

## Test plan
- Reset release, RESET_PC=0, 1-cycle memory returning `addr*4+0x100`, no stall -> `imem_addr` 0,1,2,... one per cycle. `inst` sequence 0x100,0x104,... from cycle 3, with `next_pc` = 4,8,12,... and `id_valid`=1.
- Stall held 4 cycles mid-stream -> `inst`/`next_pc` frozen. `imem_req` drops once queue+outstanding = 2. After release, the sequence resumes with no skipped or duplicated word.
- Redirect to 12'h040 with 2 requests outstanding, 3-cycle memory latency -> both stale responses dropped (`disc_q` 2->0). Next valid IF/ID: `next_pc`=13'h044. No `id_valid` pulse for stale words.
- Redirect asserted together with `stall` and a same-cycle `imem_rvalid` -> IF/ID becomes NOP/`id_valid`=0, the response is dropped, and `pc_q`=target next cycle.
- Fetch at 13'h1FFC -> `next_pc`=13'h0000 and the following `imem_addr`=0 (wrap).
- Assert `rst` while 2 requests are outstanding and the queue holds 1 entry -> outputs immediately `inst`=0x13, `id_valid`=0, `imem_req`=0. After release, fetch restarts at RESET_PC.
